// File: rtl/cmul_share_arb.sv
// cmul_share_arb: shares one complex-multiplier pipeline between two
// AXI-stream requesters. Arbitration is packet-granular round-robin.
// Issue is gated by per-channel credits so every product has FIFO room.
module cmul_share_arb #(
  parameter int DATA_WIDTH    = 16,
  parameter int SCALING_WIDTH = 18,
  parameter int MULT_LATENCY  = 6,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*DATA_WIDTH-1:0]   s0_adata,
  input  logic [2*DATA_WIDTH-1:0]   s0_bdata,
  input  logic [SCALING_WIDTH-1:0]  s0_scale,
  input  logic                      s0_tvalid,
  input  logic                      s0_tlast,
  output logic                      s0_tready,
  input  logic [2*DATA_WIDTH-1:0]   s1_adata,
  input  logic [2*DATA_WIDTH-1:0]   s1_bdata,
  input  logic [SCALING_WIDTH-1:0]  s1_scale,
  input  logic                      s1_tvalid,
  input  logic                      s1_tlast,
  output logic                      s1_tready,
  output logic [2*DATA_WIDTH-1:0]   m_adata,
  output logic [2*DATA_WIDTH-1:0]   m_bdata,
  output logic [SCALING_WIDTH-1:0]  m_scale,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic [2*DATA_WIDTH-1:0]   m_pdata,
  output logic [2*DATA_WIDTH-1:0]   o0_pdata,
  output logic                      o0_tvalid,
  output logic                      o0_tlast,
  input  logic                      o0_tready,
  output logic [2*DATA_WIDTH-1:0]   o1_pdata,
  output logic                      o1_tvalid,
  output logic                      o1_tlast,
  input  logic                      o1_tready,
  output logic [1:0]                grant
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CH0, CH1} state_t;

  state_t                   state_q, state_d;
  logic                     rr_q, rr_d;
  logic [CW-1:0]            occ0_q, occ0_d, occ1_q, occ1_d;
  logic [CW-1:0]            inflight0_q, inflight0_d, inflight1_q, inflight1_d;
  logic [AW-1:0]            wr0_q, wr0_d, rd0_q, rd0_d;
  logic [AW-1:0]            wr1_q, wr1_d, rd1_q, rd1_d;
  logic [SW-1:0]            m_adata_q, m_adata_d, m_bdata_q, m_bdata_d;
  logic [SCALING_WIDTH-1:0] m_scale_q, m_scale_d;
  logic                     m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic                     m_ch_q, m_ch_d;
  logic [MULT_LATENCY-1:0]  tag_vld_q, tag_vld_d, tag_ch_q, tag_ch_d;
  logic [MULT_LATENCY-1:0]  tag_last_q, tag_last_d;
  logic [SW:0]              mem0 [FIFO_DEPTH];
  logic [SW:0]              mem1 [FIFO_DEPTH];
  logic                     acc0, acc1, push0, push1, pop0, pop1;
  logic                     tag_out_vld, tag_out_ch, tag_out_last;

  // Credit uses registered counts only; a pop in the same cycle is not credited.
  assign s0_tready = (state_q == CH0) &&
                     (({1'b0, occ0_q} + {1'b0, inflight0_q}) < DEPTH_CNT);
  assign s1_tready = (state_q == CH1) &&
                     (({1'b0, occ1_q} + {1'b0, inflight1_q}) < DEPTH_CNT);
  assign acc0 = s0_tvalid && s0_tready;
  assign acc1 = s1_tvalid && s1_tready;

  assign tag_out_vld  = tag_vld_q[MULT_LATENCY-1];
  assign tag_out_ch   = tag_ch_q[MULT_LATENCY-1];
  assign tag_out_last = tag_last_q[MULT_LATENCY-1];
  assign push0 = tag_out_vld && !tag_out_ch;
  assign push1 = tag_out_vld && tag_out_ch;

  assign o0_tvalid = (occ0_q != '0);
  assign o1_tvalid = (occ1_q != '0);
  assign o0_pdata  = o0_tvalid ? mem0[rd0_q][SW-1:0] : '0;
  assign o1_pdata  = o1_tvalid ? mem1[rd1_q][SW-1:0] : '0;
  assign o0_tlast  = o0_tvalid && mem0[rd0_q][SW];
  assign o1_tlast  = o1_tvalid && mem1[rd1_q][SW];
  assign pop0 = o0_tvalid && o0_tready;
  assign pop1 = o1_tvalid && o1_tready;

  assign m_adata  = m_adata_q;
  assign m_bdata  = m_bdata_q;
  assign m_scale  = m_scale_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign grant    = {state_q == CH1, state_q == CH0};

  // Re-arbitrate when idle or when the owner's last beat is accepted.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if ((state_q == IDLE) || (acc0 && s0_tlast) || (acc1 && s1_tlast)) begin
      if (s0_tvalid && s1_tvalid) begin
        state_d = rr_q ? CH1 : CH0;
        rr_d    = ~rr_q;
      end else if (s0_tvalid) begin
        state_d = CH0;
        rr_d    = 1'b1;
      end else if (s1_tvalid) begin
        state_d = CH1;
        rr_d    = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Capture the accepted beat for the multiplier and shift the channel tag alongside it.
  always_comb begin
    m_adata_d  = m_adata_q;
    m_bdata_d  = m_bdata_q;
    m_scale_d  = m_scale_q;
    m_tlast_d  = m_tlast_q;
    m_ch_d     = m_ch_q;
    m_tvalid_d = acc0 || acc1;
    if (acc0) begin
      m_adata_d = s0_adata;
      m_bdata_d = s0_bdata;
      m_scale_d = s0_scale;
      m_tlast_d = s0_tlast;
      m_ch_d    = 1'b0;
    end else if (acc1) begin
      m_adata_d = s1_adata;
      m_bdata_d = s1_bdata;
      m_scale_d = s1_scale;
      m_tlast_d = s1_tlast;
      m_ch_d    = 1'b1;
    end
    tag_vld_d     = tag_vld_q << 1;
    tag_ch_d      = tag_ch_q << 1;
    tag_last_d    = tag_last_q << 1;
    tag_vld_d[0]  = m_tvalid_q;
    tag_ch_d[0]   = m_ch_q;
    tag_last_d[0] = m_tlast_q;
  end

  // Credit and occupancy bookkeeping plus FIFO pointer movement.
  always_comb begin
    inflight0_d = inflight0_q + CW'(acc0) - CW'(push0);
    inflight1_d = inflight1_q + CW'(acc1) - CW'(push1);
    occ0_d      = occ0_q + CW'(push0) - CW'(pop0);
    occ1_d      = occ1_q + CW'(push1) - CW'(pop1);
    wr0_d       = wr0_q + AW'(push0);
    wr1_d       = wr1_q + AW'(push1);
    rd0_d       = rd0_q + AW'(pop0);
    rd1_d       = rd1_q + AW'(pop1);
  end

  // State registers; reset drops every tag so products still in the multiplier are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      occ0_q      <= '0;
      occ1_q      <= '0;
      inflight0_q <= '0;
      inflight1_q <= '0;
      wr0_q       <= '0;
      wr1_q       <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      m_adata_q   <= '0;
      m_bdata_q   <= '0;
      m_scale_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_ch_q      <= 1'b0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      tag_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      occ0_q      <= occ0_d;
      occ1_q      <= occ1_d;
      inflight0_q <= inflight0_d;
      inflight1_q <= inflight1_d;
      wr0_q       <= wr0_d;
      wr1_q       <= wr1_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      m_adata_q   <= m_adata_d;
      m_bdata_q   <= m_bdata_d;
      m_scale_q   <= m_scale_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_ch_q      <= m_ch_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      tag_last_q  <= tag_last_d;
    end
  end

  // FIFO storage; contents are qualified by occupancy, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push0) mem0[wr0_q] <= {tag_out_last, m_pdata};
    if (push1) mem1[wr1_q] <= {tag_out_last, m_pdata};
  end

endmodule

// File: tb/tb_cmul_share_arb.sv
// Directed bench for cmul_share_arb with a 6-cycle pass-through multiplier stub.
module tb_cmul_share_arb;

  localparam int DW  = 16;
  localparam int SCW = 18;
  localparam int LAT = 6;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic [2*DW-1:0] s0_adata, s0_bdata, s1_adata, s1_bdata;
  logic [SCW-1:0]  s0_scale, s1_scale;
  logic            s0_tvalid, s0_tlast, s0_tready;
  logic            s1_tvalid, s1_tlast, s1_tready;
  logic [2*DW-1:0] m_adata, m_bdata, m_pdata;
  logic [SCW-1:0]  m_scale;
  logic            m_tvalid, m_tlast;
  logic [2*DW-1:0] o0_pdata, o1_pdata;
  logic            o0_tvalid, o0_tlast, o0_tready;
  logic            o1_tvalid, o1_tlast, o1_tready;
  logic [1:0]      grant;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2*DW-1:0] stubPipe [LAT];
  logic [32:0] gotData0[$], gotData1[$], expData0[$], expData1[$];
  int gotCyc0[$], gotCyc1[$], accCyc[$], accCh[$];
  int accN [2];

  cmul_share_arb #(
    .DATA_WIDTH(DW), .SCALING_WIDTH(SCW), .MULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_adata(s0_adata), .s0_bdata(s0_bdata), .s0_scale(s0_scale),
    .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_adata(s1_adata), .s1_bdata(s1_bdata), .s1_scale(s1_scale),
    .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_adata(m_adata), .m_bdata(m_bdata), .m_scale(m_scale),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_pdata(m_pdata),
    .o0_pdata(o0_pdata), .o0_tvalid(o0_tvalid), .o0_tlast(o0_tlast), .o0_tready(o0_tready),
    .o1_pdata(o1_pdata), .o1_tvalid(o1_tvalid), .o1_tlast(o1_tlast), .o1_tready(o1_tready),
    .grant(grant)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter, read at negedges to timestamp accepts and output beats.
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: the product is adata delayed by LAT cycles, never reset.
  always @(posedge clk) begin
    stubPipe[0] <= m_adata;
    for (int i = 1; i < LAT; i++) stubPipe[i] <= stubPipe[i-1];
  end
  assign m_pdata = stubPipe[LAT-1];

  // Output monitor: records every popped beat with its cycle stamp.
  always @(negedge clk) begin
    if (o0_tvalid && o0_tready) begin
      gotData0.push_back({o0_tlast, o0_pdata});
      gotCyc0.push_back(cyc);
    end
    if (o1_tvalid && o1_tready) begin
      gotData1.push_back({o1_tlast, o1_pdata});
      gotCyc1.push_back(cyc);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    gotData0.delete(); gotData1.delete(); expData0.delete(); expData1.delete();
    gotCyc0.delete(); gotCyc1.delete(); accCyc.delete(); accCh.delete();
    accN[0] = 0;
    accN[1] = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_adata = '0; s0_bdata = '0; s0_scale = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_adata = '0; s1_bdata = '0; s1_scale = '0;
    o0_tready = 1'b0; o1_tready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    clearLogs();
    tick();
  endtask

  task automatic checkAllZero(input string when);
    checkOutput({when, " s0_tready"}, s0_tready, 0);
    checkOutput({when, " s1_tready"}, s1_tready, 0);
    checkOutput({when, " m_tvalid"}, m_tvalid, 0);
    checkOutput({when, " m_tlast"}, m_tlast, 0);
    checkOutput({when, " o0_tvalid"}, o0_tvalid, 0);
    checkOutput({when, " o1_tvalid"}, o1_tvalid, 0);
    checkOutput({when, " o0_tlast"}, o0_tlast, 0);
    checkOutput({when, " o1_tlast"}, o1_tlast, 0);
    checkOutput({when, " grant"}, grant, 0);
    checkOutput({when, " m_adata"}, m_adata, 0);
    checkOutput({when, " m_bdata"}, m_bdata, 0);
    checkOutput({when, " m_scale"}, m_scale, 0);
    checkOutput({when, " o0_pdata"}, o0_pdata, 0);
    checkOutput({when, " o1_pdata"}, o1_pdata, 0);
  endtask

  // Drives nbeats consecutive words base, base+1, ... on one channel, tlast every pkt_len.
  task automatic applyStimulus(input int ch, input int nbeats, input int pkt_len, input logic [31:0] base);
    logic [31:0] a;
    logic last;
    int waited;
    for (int i = 0; i < nbeats; i++) begin
      a = base + 32'(i);
      last = ((i % pkt_len) == pkt_len - 1);
      if (ch == 0) begin
        s0_adata = a; s0_bdata = ~a; s0_scale = SCW'(i); s0_tlast = last; s0_tvalid = 1'b1;
      end else begin
        s1_adata = a; s1_bdata = ~a; s1_scale = SCW'(i); s1_tlast = last; s1_tvalid = 1'b1;
      end
      waited = 0;
      forever begin
        @(negedge clk);
        if ((ch == 0) ? s0_tready : s1_tready) begin
          accCyc.push_back(cyc);
          accCh.push_back(ch);
          accN[ch]++;
          if (ch == 0) expData0.push_back({last, a});
          else expData1.push_back({last, a});
          tick();
          break;
        end
        tick();
        waited++;
        if (waited > 300) begin
          checks++;
          failures++;
          $error("[TB] FAIL ch%0d accept timeout: observed=%0d accepted expected=%0d", ch, accN[ch], nbeats);
          if (ch == 0) s0_tvalid = 1'b0; else s1_tvalid = 1'b0;
          return;
        end
      end
    end
    if (ch == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    else begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((gotData0.size() < expData0.size() || gotData1.size() < expData1.size()) && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic compareStream(input int ch);
    int nGot, nExp;
    nGot = (ch == 0) ? gotData0.size() : gotData1.size();
    nExp = (ch == 0) ? expData0.size() : expData1.size();
    checkOutput($sformatf("o%0d beat count", ch), nGot, nExp);
    for (int i = 0; i < nExp && i < nGot; i++)
      checkOutput($sformatf("o%0d beat %0d", ch, i),
                  (ch == 0) ? gotData0[i] : gotData1[i],
                  (ch == 0) ? expData0[i] : expData1[i]);
  endtask

  initial begin
    int k;
    logic [32:0] expWord;
    accN[0] = 0;
    accN[1] = 0;

    // Reset state.
    reset = 1'b1;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_adata = '0; s0_bdata = '0; s0_scale = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_adata = '0; s1_bdata = '0; s1_scale = '0;
    o0_tready = 1'b0; o1_tready = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");

    // Single packet on ch0, 4 beats, with grant and result latency.
    $display("[TB] single packet");
    doReset();
    o0_tready = 1'b1; o1_tready = 1'b1;
    s0_adata = 32'h00010002; s0_bdata = 32'h0A0B0C0D; s0_scale = 18'h00123;
    s0_tlast = 1'b0; s0_tvalid = 1'b1;
    @(negedge clk);
    checkOutput("idle grant", grant, 2'b00);
    checkOutput("idle s0_tready", s0_tready, 0);
    tick();
    @(negedge clk);
    checkOutput("granted ch0", grant, 2'b01);
    checkOutput("ch0 tready", s0_tready, 1);
    checkOutput("ch1 tready while ch0 owns", s1_tready, 0);
    k = cyc;
    tick();
    s0_adata = 32'h00020003;
    @(negedge clk);
    checkOutput("m_tvalid after accept", m_tvalid, 1);
    checkOutput("m_adata beat0", m_adata, 32'h00010002);
    checkOutput("m_bdata beat0", m_bdata, 32'h0A0B0C0D);
    checkOutput("m_scale beat0", m_scale, 18'h00123);
    checkOutput("m_tlast beat0", m_tlast, 0);
    tick();
    s0_adata = 32'h00030004;
    tick();
    s0_adata = 32'h00040005; s0_tlast = 1'b1;
    tick();
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    @(negedge clk);
    checkOutput("m_adata beat3", m_adata, 32'h00040005);
    checkOutput("m_tlast beat3", m_tlast, 1);
    repeat (16) tick();
    checkOutput("single o0 count", gotData0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gotData0.size()) begin
        expWord = {(i == 3), 32'h00010002 + 32'(i) * 32'h00010001};
        checkOutput($sformatf("single o0 word %0d", i), gotData0[i], expWord);
      end
    end
    if (gotCyc0.size() == 4) begin
      checkOutput("single first result latency", gotCyc0[0], k + LAT + 2);
      checkOutput("single last result cycle", gotCyc0[3], k + LAT + 5);
    end
    checkOutput("single o1 silent", gotData1.size(), 0);

    // Contention: both channels stream four 3-beat packets each.
    $display("[TB] contention");
    doReset();
    o0_tready = 1'b1; o1_tready = 1'b1;
    fork
      applyStimulus(0, 12, 3, 32'h10000000);
      applyStimulus(1, 12, 3, 32'h20000000);
    join
    waitDrain();
    checkOutput("contention accept count", accCyc.size(), 24);
    for (int j = 0; j < 24 && j < accCyc.size(); j++) begin
      checkOutput($sformatf("contention owner beat %0d", j), accCh[j], (j / 3) % 2);
      checkOutput($sformatf("contention no gap beat %0d", j), accCyc[j] - accCyc[0], j);
    end
    compareStream(0);
    compareStream(1);

    // Backpressure: o0 blocked, ch0 fills its 16 credits, ch1 still served.
    $display("[TB] backpressure");
    doReset();
    o0_tready = 1'b0; o1_tready = 1'b1;
    fork
      begin
        applyStimulus(0, 16, 16, 32'h30000000);
        applyStimulus(0, 4, 4, 32'h30000010);
      end
      applyStimulus(1, 6, 3, 32'h40000000);
      begin
        repeat (60) tick();
        @(negedge clk);
        checkOutput("bp ch0 accepted", accN[0], 16);
        checkOutput("bp s0_tready stalled", s0_tready, 0);
        checkOutput("bp grant held by ch0", grant, 2'b01);
        checkOutput("bp ch1 accepted", accN[1], 3);
        checkOutput("bp o1 served", gotData1.size(), 3);
        checkOutput("bp o0 held", gotData0.size(), 0);
        checkOutput("bp o0_tvalid", o0_tvalid, 1);
        tick();
        o0_tready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp ch0 total accepted", accN[0], 20);
    compareStream(0);
    compareStream(1);

    // Full rate: one 100-beat packet on ch0.
    $display("[TB] full rate");
    doReset();
    o0_tready = 1'b1; o1_tready = 1'b1;
    applyStimulus(0, 100, 100, 32'h50000000);
    waitDrain();
    checkOutput("full accept count", accCyc.size(), 100);
    checkOutput("full output count", gotCyc0.size(), 100);
    if (accCyc.size() == 100 && gotCyc0.size() == 100) begin
      checkOutput("full accept span", accCyc[99] - accCyc[0], 99);
      checkOutput("full output span", gotCyc0[99] - gotCyc0[0], 99);
      checkOutput("full first latency", gotCyc0[0], accCyc[0] + LAT + 2);
    end
    compareStream(0);

    // Reset with three beats inside the multiplier.
    $display("[TB] reset mid-flight");
    doReset();
    o0_tready = 1'b1; o1_tready = 1'b1;
    applyStimulus(0, 3, 8, 32'h60000000);
    s0_adata = 32'h60000003; s0_bdata = 32'h9FFFFFFC; s0_tvalid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("mid-flight reset");
    tick();
    reset = 1'b0;
    s0_tvalid = 1'b0;
    clearLogs();
    @(negedge clk);
    checkOutput("post-reset grant", grant, 2'b00);
    repeat (22) tick();
    checkOutput("post-reset o0 silent", gotData0.size(), 0);
    checkOutput("post-reset o1 silent", gotData1.size(), 0);
    checkOutput("post-reset grant idle", grant, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmul_share_arb.md
# cmul_share_arb

Shares one `cmul_16` complex-multiplier pipeline between two AXI-stream requester channels. Arbitration is packet-granular round-robin. Each product is tagged with its source channel and routed back into a per-channel output FIFO. A credit scheme covers the multiplier's fixed, non-stallable latency: beats are issued only when their result is guaranteed FIFO space. The block sits between two DSP sources (e.g. mixer and correlator paths) and the single `cmul_16` instance. It drives that instance's `adata`/`bdata`/`in_tvalid`/`in_tlast`/`scale_val`, with `out_tready` tied high.

## Interface
- `DATA_WIDTH`, 16: I/Q component width; samples are `{I,Q}` with `2*DATA_WIDTH` bits.
- `SCALING_WIDTH`, 18: multiplier scale word width.
- `MULT_LATENCY`, 6: cycles from a beat on `m_*` to its product on `m_pdata`. Range 1..15.
- `FIFO_DEPTH`, 16: entries per output FIFO. Power of 2, ≥2. Must be ≥`MULT_LATENCY`+3 for full rate.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `s0_adata`, `s0_bdata`  in  2*DATA_WIDTH  channel-0 operands.
- `s0_scale`  in  SCALING_WIDTH  channel-0 scale, captured per beat.
- `s0_tvalid`, `s0_tlast`  in  1;  `s0_tready`  out  1.
- `s1_*`: same set for channel 1.
- `m_adata`, `m_bdata`  out  2*DATA_WIDTH  operands to multiplier.
- `m_scale`  out  SCALING_WIDTH  scale to multiplier.
- `m_tvalid`, `m_tlast`  out  1  multiplier input qualifiers.
- `m_pdata`  in  2*DATA_WIDTH  multiplier product.
- `o0_pdata`  out  2*DATA_WIDTH;  `o0_tvalid`, `o0_tlast`  out  1;  `o0_tready`  in  1.
- `o1_*`: same set for channel 1.
- `grant`  out  2  one-hot current owner; 0 when IDLE.

## Operation
- FSM states: IDLE, CH0, CH1. Reset → IDLE, round-robin pointer `rr`=0 (favours ch0).
- Arbitration in IDLE, or on the accepting edge of a `tlast` beat:
  - both `tvalid` high → take the channel `rr` points at;
  - one high → take that channel;
  - none → IDLE.
  - `rr` flips to the other channel whenever a channel is granted.
- No interleaving within a packet. The owner keeps the resource until its `tlast` beat is accepted.
- `sN_tready` = (state==CHN) && (`occN` + `inflightN` < `FIFO_DEPTH`). It does not depend on `sN_tvalid`. In IDLE, both treadys are 0.
- On accept: `adata`/`bdata`/`scale`/`tlast` are registered into `m_*`, and `m_tvalid`=1 the next cycle. With no accept, `m_tvalid`=0 and the data registers hold.
- Tag shift register, length `MULT_LATENCY`, carries {valid, ch, last}. It enters in step with `m_tvalid`.
- When the tag exits valid, `m_pdata` and `last` are written to FIFO[ch]. Counter updates: `inflightN` decrements and `occN` increments.
- `inflightN` increments on accept. Pop (`oN_tvalid && oN_tready`) decrements `occN`. Simultaneous push and pop leaves `occN` unchanged.
- FIFOs are show-ahead: `oN_tvalid` = (`occN`≠0). Order is preserved per channel.
- Credit check uses registered counts only, so overflow is impossible; a same-cycle pop is not credited.
- Reset mid-operation: all tags, counters and FIFOs clear immediately. Products still in the multiplier emerge with invalid tags and are discarded.

## Timing
- Reset values: `s*_tready`, `m_tvalid`, `m_tlast`, `o*_tvalid`, `o*_tlast`, `grant` = 0. `m_adata`, `m_bdata`, `m_scale`, `o*_pdata` = 0.
- Grant latency: valid seen in IDLE at edge E → state CHN after E; first accept at E+1.
- Back-to-back packets: a `tlast` accept re-arbitrates on the same edge, with no bubble, when the other channel (or the same one) is valid.
- Result latency: accept at edge E → `m_tvalid` in cycle after E → FIFO write at edge E+1+`MULT_LATENCY` → `oN_tvalid` high after that edge. This is `MULT_LATENCY`+2 edges after accept (8 at default).
- Throughput: 1 beat/cycle while owner valid and credit available.

## Test plan
- Reset: hold `reset` mid-stream → all outputs listed above read 0 combinationally-after-reset. After release, `grant`=0 until a valid is seen.
- Single packet: `MULT_LATENCY`=6 stub (`pdata`=`adata` delayed 6); ch0 sends 4 beats 0x00010002..0x00040005, `tlast` on 4th → `o0` emits the same 4 words in order, `tlast` on the 4th. The first appears 8 edges after its accept; `o1` stays silent.
- Contention: both channels stream continuous 3-beat packets → `grant` sequence 01,10,01,10… with no gap cycles. Each output receives only its own data with no interleaving.
- Backpressure: `o0_tready`=0, ch0 streaming → exactly 16 beats accepted, then `s0_tready`=0. After ch0's `tlast`, ch1 packets are still served. Raising `o0_tready` drains 16 words, then acceptance resumes.
- Full rate: one 100-beat ch0 packet with `o0_tready`=1 → `s0_tready` is high for 100 consecutive cycles, and 100 contiguous `o0` beats appear.
- Reset mid-flight: assert `reset` with 3 beats in the multiplier → after release, no stale product appears on `o0`/`o1` within 20 cycles.
